// File: rtl/audio_mod_core.sv
// audio_mod_core: two-channel audio modulation front end.
// Module_SIG is CH1 mixed with a triangle-carrier AM subcarrier that carries CH2.
// Fre_word is a DDS frequency word: BASE plus the FM offset Move_Fre_SIG * GAIN.
// Modulation parameters live in shadow registers. A commit copies them to the
// active set in one step.
//
// Ports:
//   clk_in        system clock
//   RST           asynchronous reset, active-high
//   Audio_CH1     baseband audio (signed)
//   Audio_CH2     audio carried on the AM subcarrier (signed)
//   Move_Fre_SIG  frequency-shift control (signed)
//   cfg_we        shadow register write strobe
//   cfg_addr      register address (0 CENTER, 1 DEEP, 2 BASE, 3 GAIN, 4 MODE, 5 sat clear)
//   cfg_wdata     write data
//   cfg_commit    copy all shadow registers to the active set
//   Module_SIG    modulated audio (signed, saturated)
//   Fre_word      DDS frequency word
//   out_valid     pipeline primed
//   sat_flag      sticky saturation indicator
module audio_mod_core #(
    parameter int unsigned IN_WIDTH    = 12,
    parameter int unsigned OUT_WIDTH   = 12,
    parameter int unsigned PHASE_WIDTH = 32,
    parameter int unsigned GAIN_WIDTH  = 20
) (
    input  logic                   clk_in,
    input  logic                   RST,
    input  logic [IN_WIDTH-1:0]    Audio_CH1,
    input  logic [IN_WIDTH-1:0]    Audio_CH2,
    input  logic [IN_WIDTH-1:0]    Move_Fre_SIG,
    input  logic                   cfg_we,
    input  logic [2:0]             cfg_addr,
    input  logic [31:0]            cfg_wdata,
    input  logic                   cfg_commit,
    output logic [OUT_WIDTH-1:0]   Module_SIG,
    output logic [PHASE_WIDTH-1:0] Fre_word,
    output logic                   out_valid,
    output logic                   sat_flag
);

    localparam int unsigned DeepW = 16;
    localparam int unsigned ProdW = IN_WIDTH + DeepW + 1;
    localparam int unsigned EnvW  = IN_WIDTH + 2;
    localparam int unsigned FmW   = IN_WIDTH + GAIN_WIDTH;
    localparam int unsigned TriW  = OUT_WIDTH + 1;
    localparam int unsigned AmW   = EnvW + OUT_WIDTH;
    localparam int unsigned MixW  = AmW + 2;

    localparam logic [PHASE_WIDTH-1:0] CenterRst = PHASE_WIDTH'(858993);
    localparam logic [DeepW-1:0]       DeepRst   = DeepW'(32768);
    localparam logic [PHASE_WIDTH-1:0] BaseRst   = PHASE_WIDTH'(416611827);
    localparam logic [GAIN_WIDTH-1:0]  GainRst   = GAIN_WIDTH'(10486);

    localparam logic signed [EnvW-1:0] EnvBias = EnvW'(1 << (IN_WIDTH - 1));
    localparam logic signed [TriW-1:0] TriHalf = TriW'(1 << (OUT_WIDTH - 1));
    localparam logic signed [TriW-1:0] TriPeak = TriW'((1 << (OUT_WIDTH - 1)) - 1);
    localparam logic signed [MixW-1:0] SatMax  = MixW'((1 << (OUT_WIDTH - 1)) - 1);
    localparam logic signed [MixW-1:0] SatMin  = MixW'(-(1 << (OUT_WIDTH - 1)));

    // ---------------- configuration: shadow and active sets ----------------
    logic [PHASE_WIDTH-1:0] center_sh_q, center_sh_d, center_q, center_d;
    logic [DeepW-1:0]       deep_sh_q, deep_sh_d, deep_q, deep_d;
    logic [PHASE_WIDTH-1:0] base_sh_q, base_sh_d, base_q, base_d;
    logic [GAIN_WIDTH-1:0]  gain_sh_q, gain_sh_d, gain_q, gain_d;
    logic [2:0]             mode_sh_q, mode_sh_d, mode_q, mode_d;
    logic                   sat_clr;

    always_comb begin
        center_sh_d = center_sh_q;
        deep_sh_d   = deep_sh_q;
        base_sh_d   = base_sh_q;
        gain_sh_d   = gain_sh_q;
        mode_sh_d   = mode_sh_q;
        if (cfg_we) begin
            case (cfg_addr)
                3'd0:    center_sh_d = PHASE_WIDTH'(cfg_wdata);
                3'd1:    deep_sh_d   = cfg_wdata[DeepW-1:0];
                3'd2:    base_sh_d   = PHASE_WIDTH'(cfg_wdata);
                3'd3:    gain_sh_d   = GAIN_WIDTH'(cfg_wdata);
                3'd4:    mode_sh_d   = cfg_wdata[2:0];
                default: ;
            endcase
        end
        // Commit takes the post-write shadow so a same-cycle write is included.
        center_d = cfg_commit ? center_sh_d : center_q;
        deep_d   = cfg_commit ? deep_sh_d   : deep_q;
        base_d   = cfg_commit ? base_sh_d   : base_q;
        gain_d   = cfg_commit ? gain_sh_d   : gain_q;
        mode_d   = cfg_commit ? mode_sh_d   : mode_q;
    end

    assign sat_clr = cfg_we && (cfg_addr == 3'd5);

    always_ff @(posedge clk_in or posedge RST) begin
        if (RST) begin
            center_sh_q <= CenterRst;
            deep_sh_q   <= DeepRst;
            base_sh_q   <= BaseRst;
            gain_sh_q   <= GainRst;
            mode_sh_q   <= 3'd0;
            center_q    <= CenterRst;
            deep_q      <= DeepRst;
            base_q      <= BaseRst;
            gain_q      <= GainRst;
            mode_q      <= 3'd0;
        end else begin
            center_sh_q <= center_sh_d;
            deep_sh_q   <= deep_sh_d;
            base_sh_q   <= base_sh_d;
            gain_sh_q   <= gain_sh_d;
            mode_sh_q   <= mode_sh_d;
            center_q    <= center_d;
            deep_q      <= deep_d;
            base_q      <= base_d;
            gain_q      <= gain_d;
            mode_q      <= mode_d;
        end
    end

    // ---------------- NCO and triangle carrier ----------------
    logic [PHASE_WIDTH-1:0]      acc_q, acc_d;
    logic [OUT_WIDTH-1:0]        tri_u;
    logic signed [TriW-1:0]      tri_w;
    logic signed [OUT_WIDTH-1:0] tri_c;
    logic                        unused_tri_msb;

    assign acc_d = acc_q + center_q;
    assign tri_u = acc_q[PHASE_WIDTH-2 -: OUT_WIDTH];

    // Rising ramp in the first half-period, falling ramp in the second.
    always_comb begin
        if (!acc_q[PHASE_WIDTH-1]) begin
            tri_w = $signed({1'b0, tri_u}) - TriHalf;
        end else begin
            tri_w = TriPeak - $signed({1'b0, tri_u});
        end
    end

    // Both ramps stay inside the OUT_WIDTH signed range, so the top bit is redundant.
    assign tri_c          = tri_w[OUT_WIDTH-1:0];
    assign unused_tri_msb = tri_w[OUT_WIDTH];

    // ---------------- stage 1: envelope, FM carry, CH1 alignment ----------------
    logic signed [ProdW-1:0]     m_prod, m_shr;
    logic signed [EnvW-1:0]      env_d;
    logic signed [FmW-1:0]       fm_prod;
    logic [PHASE_WIDTH-1:0]      carry_d;
    logic signed [OUT_WIDTH-1:0] ch1_s;

    assign m_prod  = ProdW'($signed(Audio_CH2)) * ProdW'($signed({1'b0, deep_q}));
    assign m_shr   = m_prod >>> DeepW;
    assign env_d   = EnvW'(m_shr) + EnvBias;
    assign fm_prod = FmW'($signed(Move_Fre_SIG)) * FmW'($signed(gain_q));
    // MODE[2] disables FM by zeroing the offset, leaving Fre_word = BASE.
    assign carry_d = mode_q[2] ? '0 : PHASE_WIDTH'(fm_prod);

    if (OUT_WIDTH >= IN_WIDTH) begin : g_ch1_ext
        assign ch1_s = OUT_WIDTH'($signed(Audio_CH1));
    end else begin : g_ch1_shr
        assign ch1_s = OUT_WIDTH'($signed(Audio_CH1) >>> (IN_WIDTH - OUT_WIDTH));
    end

    logic signed [EnvW-1:0]      env_q;
    logic signed [OUT_WIDTH-1:0] tri_q;
    logic [PHASE_WIDTH-1:0]      carry_q, base_s1_q;
    logic signed [OUT_WIDTH-1:0] ch1_s1_q;
    logic [1:0]                  mode_s1_q;

    // ---------------- stage 2: AM product, frequency word ----------------
    logic signed [AmW-1:0]       am_prod, am_d, am_q;
    logic [PHASE_WIDTH-1:0]      fw_q;
    logic signed [OUT_WIDTH-1:0] ch1_s2_q;
    logic [1:0]                  mode_s2_q;

    assign am_prod = AmW'(env_q) * AmW'(tri_q);
    assign am_d    = am_prod >>> IN_WIDTH;

    // ---------------- stage 3: mix select and saturation ----------------
    logic signed [MixW-1:0]  ch1_m, am_m, mix;
    logic [OUT_WIDTH-1:0]    mod_d, mod_q;
    logic [PHASE_WIDTH-1:0]  fre_q;
    logic                    clip, sat_d, sat_q;
    logic [2:0]              vld_q;

    assign ch1_m = MixW'(ch1_s2_q);
    assign am_m  = MixW'(am_q);

    always_comb begin
        mix = ch1_m + am_m;
        case (mode_s2_q)
            2'd0: mix = ch1_m + am_m;
            2'd1: mix = ch1_m;
            2'd2: mix = am_m;
            2'd3: mix = ch1_m - am_m;
            default: ;
        endcase
        clip  = 1'b0;
        mod_d = mix[OUT_WIDTH-1:0];
        if (mix > SatMax) begin
            clip  = 1'b1;
            mod_d = SatMax[OUT_WIDTH-1:0];
        end else if (mix < SatMin) begin
            clip  = 1'b1;
            mod_d = SatMin[OUT_WIDTH-1:0];
        end
    end

    // A clear request beats a simultaneous clip.
    assign sat_d = sat_clr ? 1'b0 : (sat_q | clip);

    // Config values travel with each sample, so a commit never disturbs samples in flight.
    always_ff @(posedge clk_in or posedge RST) begin
        if (RST) begin
            acc_q     <= '0;
            env_q     <= '0;
            tri_q     <= '0;
            carry_q   <= '0;
            base_s1_q <= '0;
            ch1_s1_q  <= '0;
            mode_s1_q <= '0;
            am_q      <= '0;
            fw_q      <= '0;
            ch1_s2_q  <= '0;
            mode_s2_q <= '0;
            mod_q     <= '0;
            fre_q     <= '0;
            sat_q     <= 1'b0;
            vld_q     <= '0;
        end else begin
            acc_q     <= acc_d;
            env_q     <= env_d;
            tri_q     <= tri_c;
            carry_q   <= carry_d;
            base_s1_q <= base_q;
            ch1_s1_q  <= ch1_s;
            mode_s1_q <= mode_q[1:0];
            am_q      <= am_d;
            fw_q      <= base_s1_q + carry_q;
            ch1_s2_q  <= ch1_s1_q;
            mode_s2_q <= mode_s1_q;
            mod_q     <= mod_d;
            fre_q     <= fw_q;
            sat_q     <= sat_d;
            vld_q     <= {vld_q[1:0], 1'b1};
        end
    end

    assign Module_SIG = mod_q;
    assign Fre_word   = fre_q;
    assign out_valid  = vld_q[2];
    assign sat_flag   = sat_q;

endmodule

// File: tb/tb_audio_mod_core.sv
// tb_audio_mod_core: self-checking bench for audio_mod_core.
// An arithmetic reference model predicts every output, one cycle at a time.
// Directed sequences and a randomized phase drive the design.
module tb_audio_mod_core;

    localparam int unsigned IW = 12;
    localparam int unsigned OW = 12;
    localparam int unsigned PW = 32;
    localparam int unsigned GW = 20;

    logic          clk_in = 1'b0;
    logic          RST = 1'b1;
    logic [IW-1:0] ch1, ch2, move;
    logic          cfg_we, cfg_commit;
    logic [2:0]    cfg_addr;
    logic [31:0]   cfg_wdata;
    logic [OW-1:0] module_sig;
    logic [PW-1:0] fre_word;
    logic          out_valid, sat_flag;

    always #5 clk_in = ~clk_in;

    audio_mod_core #(
        .IN_WIDTH    (IW),
        .OUT_WIDTH   (OW),
        .PHASE_WIDTH (PW),
        .GAIN_WIDTH  (GW)
    ) u_dut (
        .clk_in       (clk_in),
        .RST          (RST),
        .Audio_CH1    (ch1),
        .Audio_CH2    (ch2),
        .Move_Fre_SIG (move),
        .cfg_we       (cfg_we),
        .cfg_addr     (cfg_addr),
        .cfg_wdata    (cfg_wdata),
        .cfg_commit   (cfg_commit),
        .Module_SIG   (module_sig),
        .Fre_word     (fre_word),
        .out_valid    (out_valid),
        .sat_flag     (sat_flag)
    );

    int unsigned n_cmp;
    int unsigned n_mis;

    task automatic check_eq(input string tag, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_mis++;
            $display("FAIL %s: got %0d, want %0d", tag, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    longint acc_m;
    longint c_sh, c_act, d_sh, d_act, b_sh, b_act, g_sh, g_act, md_sh, md_act;
    bit     sat_m;
    longint q_mod[$];
    longint q_fw[$];
    bit     q_clip[$];
    longint exp_mod, exp_fw;
    bit     exp_vld;
    longint max_seen, min_seen;

    function automatic void model_reset();
        acc_m = 0;
        c_sh = 858993;    c_act = 858993;
        d_sh = 32768;     d_act = 32768;
        b_sh = 416611827; b_act = 416611827;
        g_sh = 10486;     g_act = 10486;
        md_sh = 0;        md_act = 0;
        sat_m = 0;
        q_mod.delete();
        q_fw.delete();
        q_clip.delete();
        exp_mod = 0;
        exp_fw  = 0;
        exp_vld = 0;
    endfunction

    function automatic longint tri_of(input longint acc);
        longint u = (acc >> (PW - 1 - OW)) & ((longint'(1) << OW) - 1);
        longint half = longint'(1) << (OW - 1);
        if (((acc >> (PW - 1)) & 1) == 0) return u - half;
        return half - 1 - u;
    endfunction

    function automatic longint sext_gain(input longint w);
        longint v = w & ((longint'(1) << GW) - 1);
        if (v >= (longint'(1) << (GW - 1))) v = v - (longint'(1) << GW);
        return v;
    endfunction

    // Expected result of the sample presented this cycle.
    function automatic void model_capture();
        longint a   = $signed(ch1);
        longint b   = $signed(ch2);
        longint mv  = $signed(move);
        longint tv  = tri_of(acc_m);
        longint m   = (b * d_act) >>> 16;
        longint env = 2048 + m;
        longint am  = (env * tv) >>> IW;
        longint y;
        longint fw;
        bit     clip;
        case (md_act & 3)
            0:       y = a + am;
            1:       y = a;
            2:       y = am;
            default: y = a - am;
        endcase
        clip = (y > 2047) || (y < -2048);
        if (y > 2047) y = 2047;
        if (y < -2048) y = -2048;
        if ((md_act & 4) != 0) fw = b_act;
        else fw = (b_act + mv * g_act) & 64'hFFFF_FFFF;
        q_mod.push_back(y);
        q_fw.push_back(fw);
        q_clip.push_back(clip);
    endfunction

    // State change at a rising edge.
    function automatic void model_advance(input bit we, input logic [2:0] addr,
                                          input logic [31:0] data, input bit commit);
        bit     clr = 0;
        bit     c = 0;
        longint w = data;
        acc_m = (acc_m + c_act) & 64'hFFFF_FFFF;
        if (we) begin
            case (addr)
                3'd0:    c_sh = w;
                3'd1:    d_sh = w & 16'hFFFF;
                3'd2:    b_sh = w;
                3'd3:    g_sh = sext_gain(w);
                3'd4:    md_sh = w & 7;
                3'd5:    clr = 1;
                default: ;
            endcase
        end
        if (commit) begin
            c_act = c_sh; d_act = d_sh; b_act = b_sh; g_act = g_sh; md_act = md_sh;
        end
        if (q_mod.size() == 3) begin
            exp_mod = q_mod.pop_front();
            exp_fw  = q_fw.pop_front();
            c       = q_clip.pop_front();
            exp_vld = 1;
        end
        sat_m = clr ? 1'b0 : (sat_m | c);
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic cycle(input bit we, input logic [2:0] addr, input logic [31:0] data,
                         input bit commit);
        longint ms;
        cfg_we     = we;
        cfg_addr   = addr;
        cfg_wdata  = data;
        cfg_commit = commit;
        model_capture();
        @(posedge clk_in);
        model_advance(we, addr, data, commit);
        #1;
        ms = $signed(module_sig);
        check_eq("module_sig", ms, exp_mod);
        check_eq("fre_word", fre_word, exp_fw);
        check_eq("out_valid", out_valid, exp_vld);
        check_eq("sat_flag", sat_flag, sat_m);
        if (ms > max_seen) max_seen = ms;
        if (ms < min_seen) min_seen = ms;
        @(negedge clk_in);
        cfg_we     = 1'b0;
        cfg_commit = 1'b0;
    endtask

    task automatic tick();
        cycle(1'b0, 3'd0, 32'd0, 1'b0);
    endtask

    task automatic check_zero(input string pfx);
        check_eq({pfx, "_module_sig"}, module_sig, 0);
        check_eq({pfx, "_fre_word"}, fre_word, 0);
        check_eq({pfx, "_out_valid"}, out_valid, 0);
        check_eq({pfx, "_sat_flag"}, sat_flag, 0);
    endtask

    // Asserts RST between edges; outputs must clear without a clock edge.
    task automatic reset_pulse();
        #2 RST = 1'b1;
        #1 check_zero("async_rst");
        @(negedge clk_in);
        RST = 1'b0;
        model_reset();
    endtask

    initial begin
        n_cmp = 0;
        n_mis = 0;
        ch1 = '0; ch2 = '0; move = '0;
        cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0; cfg_commit = 1'b0;
        max_seen = 0;
        min_seen = 0;
        model_reset();
        repeat (2) @(negedge clk_in);
        check_zero("reset");
        RST = 1'b0;

        // Defaults and out_valid timing
        tick();
        tick();
        check_eq("valid_before_3rd_edge", out_valid, 0);
        tick();
        check_eq("valid_3rd_edge", out_valid, 1);
        check_eq("fw_default", fre_word, 416611827);
        check_eq("sat_default", sat_flag, 0);

        // FM
        move = 12'd1;
        repeat (3) tick();
        check_eq("fw_move_p1", fre_word, 416622313);
        move = 12'hFFF;
        repeat (3) tick();
        check_eq("fw_move_m1", fre_word, 416601341);
        cycle(1'b1, 3'd4, 32'd4, 1'b1);
        for (int i = 0; i < 8; i++) begin
            move = IW'($urandom);
            tick();
        end
        check_eq("fw_fm_off", fre_word, 416611827);

        // MODE=1 passes CH1
        move = '0;
        cycle(1'b1, 3'd4, 32'd1, 1'b1);
        ch1 = 12'd100;
        repeat (3) tick();
        check_eq("mode1_ch1_100", $signed(module_sig), 100);
        ch1 = 12'h800;
        repeat (3) tick();
        check_eq("mode1_ch1_min", $signed(module_sig), -2048);
        check_eq("mode1_no_sat", sat_flag, 0);

        // Shadow semantics: uncommitted CENTER write leaves the NCO stepping
        ch1 = '0;
        ch2 = '0;
        cycle(1'b1, 3'd4, 32'd2, 1'b1);
        cycle(1'b1, 3'd0, 32'd0, 1'b0);
        repeat (5) tick();
        cycle(1'b0, 3'd0, 32'd0, 1'b1);
        repeat (4) tick();
        check_eq("am_ch2_zero", $signed(module_sig), tri_of(acc_m) >>> 1);
        cycle(1'b1, 3'd0, 32'h0400_0000, 1'b1);
        repeat (4) tick();
        cycle(1'b1, 3'd0, 32'd0, 1'b1);
        repeat (3) tick();
        check_eq("am_frozen", $signed(module_sig), tri_of(acc_m) >>> 1);

        // DEEP=0: CH2 has no effect
        cycle(1'b1, 3'd1, 32'd0, 1'b1);
        repeat (3) tick();
        for (int i = 0; i < 4; i++) begin
            ch2 = IW'($urandom);
            tick();
            check_eq("am_deep0", $signed(module_sig), tri_of(acc_m) >>> 1);
        end
        cycle(1'b1, 3'd1, 32'($urandom_range(0, 65535)), 1'b1);
        for (int i = 0; i < 6; i++) begin
            ch2 = IW'($urandom);
            tick();
        end

        // Saturation sweep, high side then low side
        cycle(1'b1, 3'd1, 32'd65535, 1'b0);
        cycle(1'b1, 3'd4, 32'd0, 1'b0);
        cycle(1'b1, 3'd0, 32'h0400_0000, 1'b1);
        ch1 = 12'd2047;
        ch2 = 12'd2047;
        max_seen = -100000;
        min_seen = 100000;
        repeat (80) tick();
        check_eq("sat_hi_clip", max_seen, 2047);
        check_eq("sat_hi_flag", sat_flag, 1);
        ch1 = 12'h800;
        max_seen = -100000;
        min_seen = 100000;
        repeat (80) tick();
        check_eq("sat_lo_clip", min_seen, -2048);
        cycle(1'b1, 3'd4, 32'd1, 1'b1);
        ch1 = '0;
        repeat (4) tick();
        check_eq("sat_sticky", sat_flag, 1);
        cycle(1'b1, 3'd5, 32'd0, 1'b0);
        check_eq("sat_clear", sat_flag, 0);

        // Clear requests racing clip events
        cycle(1'b1, 3'd4, 32'd0, 1'b1);
        ch1 = 12'd2047;
        repeat (3) tick();
        for (int i = 0; i < 8; i++) cycle(1'b1, 3'd5, 32'd0, 1'b0);
        repeat (20) tick();

        // Mid-stream reset while outputs and sat_flag are active
        reset_pulse();
        repeat (4) tick();

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            bit          we;
            bit          cm;
            logic [2:0]  ad;
            logic [31:0] wd;
            ch1  = IW'($urandom);
            ch2  = IW'($urandom);
            move = IW'($urandom);
            we   = ($urandom_range(0, 3) == 0);
            cm   = ($urandom_range(0, 7) == 0);
            ad   = 3'($urandom_range(0, 7));
            wd   = $urandom;
            if (ad == 3'd0 && $urandom_range(0, 2) == 0) wd = 32'd0;
            cycle(we, ad, wd, cm);
            if ($urandom_range(0, 299) == 0) reset_pulse();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
